// File: rtl/compute_clock_scheduler.sv
// Compute clock scheduler: runs the gated compute clock for a cycle budget and
// freezes it so control-domain requesters get exclusive round-robin access to core state.
module compute_clock_scheduler #(
  parameter int NUM_REQ      = 4,
  parameter int CNT_W        = 48,
  parameter int GATE_LATENCY = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               locked,
  input  logic               start,
  output logic               start_ready,
  input  logic [CNT_W-1:0]   cycle_budget,
  input  logic               abort,
  input  logic [NUM_REQ-1:0] stall_req,
  output logic [NUM_REQ-1:0] stall_ack,
  output logic               compute_clock_en,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   cycles_executed,
  output logic [CNT_W-1:0]   stall_cycles
);

  localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int GATE_W = $clog2(GATE_LATENCY + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RUN    = 3'd1;
  localparam logic [2:0] S_DRAIN  = 3'd2;
  localparam logic [2:0] S_HALTED = 3'd3;
  localparam logic [2:0] S_FINISH = 3'd4;

  logic [2:0]         state_q, state_d;
  logic               en_q, en_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [CNT_W-1:0]   exec_q, exec_d;
  logic [CNT_W-1:0]   stall_q, stall_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic [GATE_W-1:0]  gate_q, gate_d;
  logic [PTR_W-1:0]   rr_q, rr_d;
  logic [PTR_W-1:0]   gidx_q, gidx_d;

  logic               pick_found;
  logic [PTR_W-1:0]   pick_idx;
  int                 cand;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    int n;
    n = (int'(p) + 1) % NUM_REQ;
    return PTR_W'(n);
  endfunction

  // First pending request at or after the round-robin pointer.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = (int'(rr_q) + i) % NUM_REQ;
      if (!pick_found && stall_req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = PTR_W'(cand);
      end
    end
  end

  assign start_ready = (state_q == S_IDLE) & locked & ~|stall_req & ~|ack_q;

  always_comb begin
    state_d = state_q;
    en_d    = 1'b0;
    done_d  = 1'b0;
    ack_d   = ack_q;
    exec_d  = exec_q;
    stall_d = stall_q;
    rem_d   = rem_q;
    gate_d  = gate_q;
    rr_d    = rr_q;
    gidx_d  = gidx_q;

    // Grants only happen while the compute clock is known to be settled.
    if (state_q == S_IDLE || state_q == S_HALTED) begin
      if (|ack_q) begin
        if (!stall_req[gidx_q]) begin
          ack_d = '0;
          rr_d  = next_ptr(gidx_q);
        end
      end else if (pick_found) begin
        gidx_d          = pick_idx;
        ack_d           = '0;
        ack_d[pick_idx] = 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start && start_ready) begin
          exec_d  = '0;
          stall_d = '0;
          if (cycle_budget == '0) begin
            done_d = 1'b1;
          end else begin
            rem_d   = cycle_budget;
            en_d    = 1'b1;
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        exec_d = exec_q + CNT_W'(1);
        rem_d  = rem_q - CNT_W'(1);
        // Budget completion wins over any stop condition in the same cycle.
        if (rem_q == CNT_W'(1)) begin
          state_d = S_FINISH;
          gate_d  = '0;
        end else if (|stall_req || abort || !locked) begin
          state_d = S_DRAIN;
          gate_d  = '0;
        end else begin
          en_d = 1'b1;
        end
      end
      S_DRAIN: begin
        stall_d = stall_q + CNT_W'(1);
        if (gate_q == GATE_W'(GATE_LATENCY - 1)) state_d = S_HALTED;
        else                                     gate_d  = gate_q + GATE_W'(1);
      end
      S_HALTED: begin
        stall_d = stall_q + CNT_W'(1);
        if (!(|ack_q) && !(|stall_req)) begin
          if (abort) begin
            state_d = S_FINISH;
            gate_d  = '0;
          end else if (locked) begin
            state_d = S_RUN;
            en_d    = 1'b1;
          end
        end
      end
      S_FINISH: begin
        if (gate_q == GATE_W'(GATE_LATENCY - 1)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          gate_d = gate_q + GATE_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      ack_q   <= '0;
      exec_q  <= '0;
      stall_q <= '0;
      rem_q   <= '0;
      gate_q  <= '0;
      rr_q    <= '0;
      gidx_q  <= '0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
      exec_q  <= exec_d;
      stall_q <= stall_d;
      rem_q   <= rem_d;
      gate_q  <= gate_d;
      rr_q    <= rr_d;
      gidx_q  <= gidx_d;
    end
  end

  assign compute_clock_en = en_q;
  assign stall_ack        = ack_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign cycles_executed  = exec_q;
  assign stall_cycles     = stall_q;

endmodule

// File: tb/tb_compute_clock_scheduler.sv
// Scoreboard bench for compute_clock_scheduler: expected run lengths and grant order
// are queued when stimulus is driven and popped when done/ack appear.
module tb_compute_clock_scheduler;
  localparam int NUM_REQ = 4;
  localparam int CNT_W   = 48;
  localparam int GL      = 2;

  logic               clock = 1'b0;
  logic               reset, locked, start, abort;
  logic [CNT_W-1:0]   cycle_budget;
  logic [NUM_REQ-1:0] stall_req, stall_ack;
  logic               start_ready, compute_clock_en, busy, done;
  logic [CNT_W-1:0]   cycles_executed, stall_cycles;

  int errors = 0;
  int checks = 0;
  logic [CNT_W-1:0] exp_exec_q[$];
  int               exp_grant_q[$];

  compute_clock_scheduler #(.NUM_REQ(NUM_REQ), .CNT_W(CNT_W), .GATE_LATENCY(GL)) dut (
    .clock(clock), .reset(reset), .locked(locked), .start(start), .start_ready(start_ready),
    .cycle_budget(cycle_budget), .abort(abort), .stall_req(stall_req), .stall_ack(stall_ack),
    .compute_clock_en(compute_clock_en), .busy(busy), .done(done),
    .cycles_executed(cycles_executed), .stall_cycles(stall_cycles));

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_start(input logic [CNT_W-1:0] b);
    cycle_budget = b;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++; if (compute_clock_en !== 1'b0) begin errors++; $display("FAIL reset_en: got %b want 0", compute_clock_en); end
    checks++; if (stall_ack !== 4'b0) begin errors++; $display("FAIL reset_ack: got %b want 0000", stall_ack); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_busy_done: got %b%b want 00", busy, done); end
    checks++; if (cycles_executed !== '0 || stall_cycles !== '0) begin errors++; $display("FAIL reset_counters: got %0d/%0d want 0/0", cycles_executed, stall_cycles); end
    reset = 1'b0;
    tick();
    checks++; if (start_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", start_ready); end
  endtask

  task automatic test_basic_run();
    int en_n, first_en, last_en, done_k, done_n;
    logic [CNT_W-1:0] exp_e;
    en_n = 0; first_en = -1; last_en = -1; done_k = -1; done_n = 0;
    exp_exec_q.push_back(CNT_W'(5));
    do_start(CNT_W'(5));
    for (int k = 1; k < 40; k++) begin
      if (compute_clock_en) begin en_n++; if (first_en < 0) first_en = k; last_en = k; end
      if (done) begin
        done_n++; if (done_k < 0) done_k = k;
        checks++;
        if (exp_exec_q.size() == 0) begin errors++; $display("FAIL basic_done_sb: unexpected done, nothing queued"); end
        else begin
          exp_e = exp_exec_q.pop_front();
          if (cycles_executed !== exp_e) begin errors++; $display("FAIL basic_exec: got %0d want %0d", cycles_executed, exp_e); end
        end
        checks++; if (stall_cycles !== '0) begin errors++; $display("FAIL basic_stall: got %0d want 0", stall_cycles); end
      end
      tick();
    end
    checks++; if (en_n != 5) begin errors++; $display("FAIL basic_en_count: got %0d want 5", en_n); end
    checks++; if (first_en != 1) begin errors++; $display("FAIL basic_en_latency: got %0d want 1", first_en); end
    checks++; if (done_n != 1 || done_k != last_en + GL + 1) begin errors++; $display("FAIL basic_done_time: got n=%0d k=%0d want n=1 k=%0d", done_n, done_k, last_en + GL + 1); end
    checks++; if (busy !== 1'b0 || start_ready !== 1'b1) begin errors++; $display("FAIL basic_idle: got busy=%b ready=%b want 0/1", busy, start_ready); end
  endtask

  task automatic test_stall();
    int en_n, low_run, gap, fall_k, ack_k, since_en, early, done_n;
    logic [CNT_W-1:0] exp_e;
    en_n = 0; low_run = 0; gap = 0; fall_k = -1; ack_k = -1; since_en = 100; early = 0; done_n = 0;
    exp_exec_q.push_back(CNT_W'(10));
    do_start(CNT_W'(10));
    for (int k = 1; k < 80; k++) begin
      if (compute_clock_en) begin en_n++; gap += low_run; low_run = 0; since_en = 0; end
      else begin
        since_en++;
        if (en_n > 0 && done_n == 0) low_run++;
        if (en_n == 3 && fall_k < 0) fall_k = k;
      end
      if (|stall_ack && (compute_clock_en || since_en <= GL)) early++;
      if (|stall_ack && ack_k < 0) begin
        ack_k = k;
        checks++; if (stall_ack !== 4'b0100) begin errors++; $display("FAIL stall_ack_value: got %b want 0100", stall_ack); end
      end
      if (done) begin
        done_n++;
        checks++;
        if (exp_exec_q.size() == 0) begin errors++; $display("FAIL stall_done_sb: unexpected done, nothing queued"); end
        else begin
          exp_e = exp_exec_q.pop_front();
          if (cycles_executed !== exp_e) begin errors++; $display("FAIL stall_exec: got %0d want %0d", cycles_executed, exp_e); end
        end
        checks++; if (stall_cycles !== CNT_W'(gap)) begin errors++; $display("FAIL stall_cycles: got %0d want %0d", stall_cycles, gap); end
      end
      if (en_n == 3 && fall_k < 0 && compute_clock_en) stall_req[2] = 1'b1;
      if (ack_k >= 0 && k == ack_k + 3) stall_req[2] = 1'b0;
      tick();
    end
    checks++; if (en_n != 10) begin errors++; $display("FAIL stall_en_total: got %0d want 10", en_n); end
    checks++; if (ack_k != fall_k + GL + 1) begin errors++; $display("FAIL stall_ack_latency: got %0d want %0d", ack_k, fall_k + GL + 1); end
    checks++; if (early != 0 || gap < 7 || done_n != 1) begin errors++; $display("FAIL stall_window: got early=%0d gap=%0d done=%0d want 0 >=7 1", early, gap, done_n); end
  endtask

  task automatic test_round_robin();
    int en_n, done_n, arb_bad, en_bad, rel_k, cur, raised;
    logic [NUM_REQ-1:0] prev_ack;
    logic [CNT_W-1:0] exp_e;
    // Grant and release requester 0 in IDLE so the pointer moves to 1.
    stall_req = 4'b0001;
    tick();
    checks++; if (stall_ack !== 4'b0001 || start_ready !== 1'b0) begin errors++; $display("FAIL rr_idle_grant: got ack=%b ready=%b want 0001/0", stall_ack, start_ready); end
    stall_req = 4'b0000;
    tick();
    tick();
    en_n = 0; done_n = 0; arb_bad = 0; en_bad = 0; rel_k = -1; cur = -1; raised = 0; prev_ack = '0;
    exp_grant_q.push_back(1); exp_grant_q.push_back(3); exp_grant_q.push_back(0);
    exp_exec_q.push_back(CNT_W'(8));
    do_start(CNT_W'(8));
    for (int k = 1; k < 120; k++) begin
      if (compute_clock_en) en_n++;
      if (!$onehot0(stall_ack)) arb_bad++;
      if (|stall_ack && |prev_ack && stall_ack != prev_ack) arb_bad++;
      if (compute_clock_en && |stall_req) en_bad++;
      if (|stall_ack && prev_ack == '0) begin
        cur = -1;
        for (int i = 0; i < NUM_REQ; i++) if (stall_ack[i]) cur = i;
        checks++;
        if (exp_grant_q.size() == 0) begin errors++; $display("FAIL rr_grant_sb: unexpected grant %0d", cur); end
        else if (exp_grant_q[0] != cur) begin errors++; $display("FAIL rr_order: got %0d want %0d", cur, exp_grant_q.pop_front()); end
        else void'(exp_grant_q.pop_front());
        rel_k = k + 2;
      end
      if (done) begin
        done_n++;
        checks++;
        if (exp_exec_q.size() == 0) begin errors++; $display("FAIL rr_done_sb: unexpected done, nothing queued"); end
        else begin
          exp_e = exp_exec_q.pop_front();
          if (cycles_executed !== exp_e) begin errors++; $display("FAIL rr_exec: got %0d want %0d", cycles_executed, exp_e); end
        end
      end
      prev_ack = stall_ack;
      if (en_n == 2 && raised == 0) begin stall_req = 4'b1011; raised = 1; end
      if (k == rel_k && cur >= 0) stall_req[cur] = 1'b0;
      tick();
    end
    checks++; if (exp_grant_q.size() != 0) begin errors++; $display("FAIL rr_missing: got %0d grants left want 0", exp_grant_q.size()); exp_grant_q.delete(); end
    checks++; if (arb_bad != 0 || en_bad != 0) begin errors++; $display("FAIL rr_exclusive: got arb=%0d en=%0d want 0/0", arb_bad, en_bad); end
    checks++; if (en_n != 8 || done_n != 1) begin errors++; $display("FAIL rr_run: got en=%0d done=%0d want 8/1", en_n, done_n); end
  endtask

  task automatic test_abort();
    int en_n, done_n, bad;
    logic [CNT_W-1:0] exp_e;
    en_n = 0; done_n = 0; bad = 0;
    exp_exec_q.push_back(CNT_W'(7));
    do_start(CNT_W'(20));
    for (int k = 1; k < 60; k++) begin
      if (compute_clock_en) en_n++;
      if (done) begin
        done_n++;
        abort = 1'b0;
        checks++;
        if (exp_exec_q.size() == 0) begin errors++; $display("FAIL abort_done_sb: unexpected done, nothing queued"); end
        else begin
          exp_e = exp_exec_q.pop_front();
          if (cycles_executed !== exp_e) begin errors++; $display("FAIL abort_exec: got %0d want %0d", cycles_executed, exp_e); end
        end
        checks++; if (stall_cycles !== CNT_W'(GL + 1)) begin errors++; $display("FAIL abort_stall: got %0d want %0d", stall_cycles, GL + 1); end
      end
      if (en_n == 7 && done_n == 0 && compute_clock_en) abort = 1'b1;
      tick();
    end
    checks++; if (done_n != 1 || en_n != 7) begin errors++; $display("FAIL abort_run: got done=%0d en=%0d want 1/7", done_n, en_n); end
    checks++; if (start_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL abort_idle: got ready=%b busy=%b want 1/0", start_ready, busy); end
    abort = 1'b1;
    for (int k = 0; k < 4; k++) begin tick(); if (busy || done || compute_clock_en) bad++; end
    abort = 1'b0;
    checks++; if (bad != 0) begin errors++; $display("FAIL abort_in_idle: got %0d active cycles want 0", bad); end
  endtask

  task automatic test_zero_budget_and_lock();
    int bad;
    logic [CNT_W-1:0] exp_e;
    exp_exec_q.push_back(CNT_W'(0));
    do_start(CNT_W'(0));
    checks++; if (done !== 1'b1 || compute_clock_en !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL zero_done: got done=%b en=%b busy=%b want 1/0/0", done, compute_clock_en, busy); end
    checks++;
    if (exp_exec_q.size() == 0) begin errors++; $display("FAIL zero_done_sb: nothing queued"); end
    else begin
      exp_e = exp_exec_q.pop_front();
      if (cycles_executed !== exp_e) begin errors++; $display("FAIL zero_exec_cleared: got %0d want %0d", cycles_executed, exp_e); end
    end
    tick();
    checks++; if (done !== 1'b0 || compute_clock_en !== 1'b0) begin errors++; $display("FAIL zero_single_pulse: got done=%b en=%b want 0/0", done, compute_clock_en); end
    locked = 1'b0;
    tick();
    checks++; if (start_ready !== 1'b0) begin errors++; $display("FAIL unlocked_ready: got %b want 0", start_ready); end
    bad = 0;
    cycle_budget = CNT_W'(5);
    start = 1'b1;
    for (int k = 0; k < 4; k++) begin tick(); if (busy || compute_clock_en || done) bad++; end
    start = 1'b0;
    locked = 1'b1;
    tick();
    checks++; if (bad != 0 || start_ready !== 1'b1) begin errors++; $display("FAIL unlocked_ignore: got bad=%0d ready=%b want 0/1", bad, start_ready); end
  endtask

  task automatic test_reset_mid_halt();
    int en_n, got;
    en_n = 0; got = 0;
    do_start(CNT_W'(10));
    for (int k = 1; k < 40 && got == 0; k++) begin
      if (compute_clock_en) en_n++;
      if (stall_ack == 4'b0010) got = 1;
      else begin
        if (en_n == 2) stall_req[1] = 1'b1;
        tick();
      end
    end
    checks++; if (got != 1) begin errors++; $display("FAIL rst_ack_wait: got no ack[1] want ack 0010"); end
    reset = 1'b1;
    stall_req = '0;
    tick();
    checks++; if (stall_ack !== 4'b0 || compute_clock_en !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_mid_outputs: got ack=%b en=%b done=%b busy=%b want 0", stall_ack, compute_clock_en, done, busy); end
    checks++; if (cycles_executed !== '0 || stall_cycles !== '0 || start_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_state: got exec=%0d stall=%0d ready=%b want 0/0/1", cycles_executed, stall_cycles, start_ready); end
    reset = 1'b0;
    tick();
    stall_req = 4'b0011;
    tick();
    checks++; if (stall_ack !== 4'b0001) begin errors++; $display("FAIL rst_rr_ptr: got %b want 0001", stall_ack); end
    stall_req = '0;
    tick();
    tick();
  endtask

  task automatic test_req_on_last();
    int en_n, done_n, done_k, ack_k, premature;
    logic [CNT_W-1:0] exp_e;
    en_n = 0; done_n = 0; done_k = -1; ack_k = -1; premature = 0;
    exp_exec_q.push_back(CNT_W'(4));
    do_start(CNT_W'(4));
    for (int k = 1; k < 30; k++) begin
      if (compute_clock_en) en_n++;
      if (|stall_ack && done_k < 0) premature++;
      if (|stall_ack && ack_k < 0) begin
        ack_k = k;
        checks++; if (stall_ack !== 4'b1000) begin errors++; $display("FAIL last_ack_value: got %b want 1000", stall_ack); end
      end
      if (done) begin
        done_n++; done_k = k;
        checks++;
        if (exp_exec_q.size() == 0) begin errors++; $display("FAIL last_done_sb: unexpected done, nothing queued"); end
        else begin
          exp_e = exp_exec_q.pop_front();
          if (cycles_executed !== exp_e || stall_cycles !== '0) begin errors++; $display("FAIL last_counts: got %0d/%0d want %0d/0", cycles_executed, stall_cycles, exp_e); end
        end
      end
      if (en_n == 4 && compute_clock_en) stall_req[3] = 1'b1;
      tick();
    end
    checks++; if (en_n != 4 || done_n != 1 || premature != 0) begin errors++; $display("FAIL last_run: got en=%0d done=%0d early=%0d want 4/1/0", en_n, done_n, premature); end
    checks++; if (ack_k != done_k + 1) begin errors++; $display("FAIL last_idle_grant: got %0d want %0d", ack_k, done_k + 1); end
    stall_req = '0;
    tick();
    tick();
  endtask

  initial begin
    reset = 1'b1; locked = 1'b1; start = 1'b0; abort = 1'b0;
    cycle_budget = '0; stall_req = '0;
    test_reset();
    test_basic_run();
    test_stall();
    test_round_robin();
    test_abort();
    test_zero_budget_and_lock();
    test_reset_mid_halt();
    test_req_on_last();
    checks++; if (exp_exec_q.size() != 0) begin errors++; $display("FAIL done_sb_leftover: got %0d pending want 0", exp_exec_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
